// File: rtl/uart_seg_terminal_if.sv
// Bus between the UART/display environment and the segment terminal.
// The slave modport is the terminal's view; master is the surrounding logic.
interface uart_seg_terminal_if #(
  parameter int DIGIT_CT = 8,
  parameter int BYTE_W   = 8
);
  localparam int SW = $clog2(DIGIT_CT);
  localparam int CW = $clog2(DIGIT_CT + 1);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [SW-1:0]     wr_sel;
  logic [7:0]        wr_seg;
  logic              clr_pulse;
  logic [CW-1:0]     cursor;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_load_ok;
  logic              rx_drop;
  logic              echo_ovf;

  modport master (
    output rx_data, rx_valid, tx_load_ok,
    input  wr_en, wr_sel, wr_seg, clr_pulse, cursor, tx_data, tx_load, rx_drop, echo_ovf
  );

  modport slave (
    input  rx_data, rx_valid, tx_load_ok,
    output wr_en, wr_sel, wr_seg, clr_pulse, cursor, tx_data, tx_load, rx_drop, echo_ovf
  );
endinterface

// File: rtl/uart_seg_terminal.sv
// UART byte stream to multi-digit 7-segment terminal: frame buffer, cursor,
// scroll/clear handling and an echo FIFO feeding the UART transmitter.
module uart_seg_terminal #(
  parameter int DIGIT_CT    = 8,
  parameter int BYTE_W      = 8,
  parameter int ECHO_DEPTH  = 4,
  parameter int SCROLL_MODE = 1,
  parameter int DOT_MERGE   = 1
) (
  input logic                  sys_clk,
  input logic                  rst,
  uart_seg_terminal_if.slave   bus
);
  localparam int SW = $clog2(DIGIT_CT);
  localparam int CW = $clog2(DIGIT_CT + 1);
  localparam int AW = $clog2(ECHO_DEPTH);
  localparam logic [CW-1:0] LINE_END = CW'(DIGIT_CT);
  localparam logic [CW-1:0] CUR_ONE  = CW'(1);
  localparam logic [SW-1:0] LAST_SEL = SW'(DIGIT_CT - 1);
  localparam logic [SW-1:0] SEL_ONE  = SW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FIFO_CAP = (AW + 1)'(ECHO_DEPTH);

  typedef enum logic [2:0] {IDLE, DECODE, WRITE, SCROLL, CLEAR} state_t;
  typedef enum logic [2:0] {ACT_IGNORE, ACT_CR, ACT_BS, ACT_FF, ACT_DOT, ACT_CHAR} act_t;

  state_t            state, state_nxt;
  act_t              act;
  logic [BYTE_W-1:0] byte_q;
  logic [7:0]        fb [DIGIT_CT];
  logic [CW-1:0]     cur;
  logic [SW-1:0]     sel_q, scan, prev_sel;
  logic [7:0]        seg_q, seg_dec;
  logic              at_end, push;

  function automatic logic [7:0] seg_of(input logic [7:0] c);
    case (c)
      8'h30: return 8'h3F;
      8'h31: return 8'h06;
      8'h32: return 8'h5B;
      8'h33: return 8'h4F;
      8'h34: return 8'h66;
      8'h35: return 8'h6D;
      8'h36: return 8'h7D;
      8'h37: return 8'h07;
      8'h38: return 8'h7F;
      8'h39: return 8'h6F;
      8'h41, 8'h61: return 8'h77;
      8'h42, 8'h62: return 8'h7C;
      8'h43, 8'h63: return 8'h39;
      8'h44, 8'h64: return 8'h5E;
      8'h45, 8'h65: return 8'h79;
      8'h46, 8'h66: return 8'h71;
      8'h2D: return 8'h40;
      8'h20: return 8'h00;
      8'h2E: return 8'h80;
      default: return 8'h08;
    endcase
  endfunction

  assign at_end   = (cur == LINE_END);
  assign prev_sel = SW'(cur - CUR_ONE);

  always_comb begin
    act     = ACT_IGNORE;
    seg_dec = seg_of(byte_q[7:0]);
    if (byte_q == BYTE_W'('h0D))      act = ACT_CR;
    else if (byte_q == BYTE_W'('h08)) act = ACT_BS;
    else if (byte_q == BYTE_W'('h0C)) act = ACT_FF;
    else if (byte_q >= BYTE_W'('h20) && byte_q <= BYTE_W'('h7E))
      act = (DOT_MERGE != 0 && byte_q == BYTE_W'('h2E) && cur != '0) ? ACT_DOT : ACT_CHAR;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.rx_valid) state_nxt = DECODE;
      DECODE: begin
        case (act)
          ACT_CHAR: state_nxt = (at_end && SCROLL_MODE != 0) ? SCROLL : WRITE;
          ACT_DOT:  state_nxt = WRITE;
          ACT_BS:   state_nxt = (cur != '0) ? WRITE : IDLE;
          ACT_FF:   state_nxt = CLEAR;
          default:  state_nxt = IDLE;
        endcase
      end
      WRITE, CLEAR: state_nxt = IDLE;
      SCROLL: if (scan == LAST_SEL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.wr_en     = 1'b0;
    bus.wr_sel    = '0;
    bus.wr_seg    = '0;
    bus.clr_pulse = 1'b0;
    push          = 1'b0;
    case (state)
      WRITE: begin
        bus.wr_en  = 1'b1;
        bus.wr_sel = sel_q;
        bus.wr_seg = seg_q;
        push       = 1'b1;
      end
      SCROLL: begin
        bus.wr_en  = 1'b1;
        bus.wr_sel = scan;
        bus.wr_seg = fb[scan];
        push       = (scan == '0);
      end
      CLEAR: bus.clr_pulse = 1'b1;
      default: ;
    endcase
  end

  assign bus.rx_drop = bus.rx_valid && (state != IDLE) && !rst;
  assign bus.cursor  = cur;

  // All buffer and cursor effects commit on the DECODE edge; WRITE/SCROLL only replay them.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DIGIT_CT; i++) fb[i] <= '0;
      cur    <= '0;
      sel_q  <= '0;
      seg_q  <= '0;
      scan   <= '0;
      byte_q <= '0;
    end else begin
      if (state == IDLE && bus.rx_valid) byte_q <= bus.rx_data;
      if (state == SCROLL) scan <= scan + SEL_ONE;
      if (state == DECODE) begin
        scan <= '0;
        case (act)
          ACT_CR: cur <= '0;
          ACT_FF: begin
            cur <= '0;
            for (int unsigned i = 0; i < DIGIT_CT; i++) fb[i] <= '0;
          end
          ACT_BS: if (cur != '0) begin
            cur          <= cur - CUR_ONE;
            fb[prev_sel] <= '0;
            sel_q        <= prev_sel;
            seg_q        <= '0;
          end
          ACT_DOT: begin
            fb[prev_sel] <= fb[prev_sel] | 8'h80;
            sel_q        <= prev_sel;
            seg_q        <= fb[prev_sel] | 8'h80;
          end
          ACT_CHAR: begin
            seg_q <= seg_dec;
            if (!at_end) begin
              fb[SW'(cur)] <= seg_dec;
              sel_q        <= SW'(cur);
              cur          <= cur + CUR_ONE;
            end else if (SCROLL_MODE != 0) begin
              for (int unsigned i = 0; i + 1 < DIGIT_CT; i++) fb[i] <= fb[i+1];
              fb[DIGIT_CT-1] <= seg_dec;
            end else begin
              fb[0] <= seg_dec;
              sel_q <= '0;
              cur   <= CUR_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [7:0]        mem [ECHO_DEPTH];
  logic [AW:0]       wp, rp;
  logic              empty, full, pop, awaiting, tx_load_q;
  logic [BYTE_W-1:0] tx_q;

  assign empty        = (wp == rp);
  assign full         = ((wp - rp) == FIFO_CAP);
  assign pop          = !empty && bus.tx_load_ok && !awaiting;
  assign bus.echo_ovf = push && full && !pop;
  assign bus.tx_load  = tx_load_q;
  assign bus.tx_data  = tx_q;

  always_ff @(posedge sys_clk) begin
    if (push && (!full || pop)) mem[wp[AW-1:0]] <= seg_q;
  end

  // After each load, tx_load_ok must be seen low before the next one may go out.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      awaiting  <= 1'b0;
      tx_load_q <= 1'b0;
      tx_q      <= '0;
    end else begin
      tx_load_q <= pop;
      if (push && (!full || pop)) wp <= wp + PTR_ONE;
      if (pop) begin
        tx_q     <= BYTE_W'(mem[rp[AW-1:0]]);
        rp       <= rp + PTR_ONE;
        awaiting <= 1'b1;
      end else if (!bus.tx_load_ok) begin
        awaiting <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_seg_terminal.sv
// Randomised bench for uart_seg_terminal with a transaction-level model
// (frame buffer array, scheduled write events, echo queue) checked every cycle.
module tb_uart_seg_terminal;
  localparam int DIGIT_CT   = 8;
  localparam int BYTE_W     = 8;
  localparam int ECHO_DEPTH = 4;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  uart_seg_terminal_if #(.DIGIT_CT(DIGIT_CT), .BYTE_W(BYTE_W)) bus ();

  uart_seg_terminal #(
    .DIGIT_CT(DIGIT_CT), .BYTE_W(BYTE_W), .ECHO_DEPTH(ECHO_DEPTH),
    .SCROLL_MODE(1), .DOT_MERGE(1)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int cyc;
  int m_fb [DIGIT_CT];
  int m_cur, shown_cur, cur_at, cur_next, idle_at;
  int wr_sel_at [int];
  int wr_seg_at [int];
  bit clr_at [int];
  int push_at [int];
  int fifo_q [$];
  bit awaiting, load_exp;
  int load_data;

  int wlog [$];
  int wcyc [$];
  int llog [$];
  int clr_count = 0, ovf_count = 0, drop_count = 0;
  bit ok_hold = 1'b0;
  int ok_busy = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int get(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int seg_model(input int c);
    int dig [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    int hex [6]  = '{'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
    if (c >= 48 && c <= 57)  return dig[c-48];
    if (c >= 65 && c <= 70)  return hex[c-65];
    if (c >= 97 && c <= 102) return hex[c-97];
    if (c == 45) return 'h40;
    if (c == 32) return 'h00;
    if (c == 46) return 'h80;
    return 'h08;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DIGIT_CT; i++) m_fb[i] = 0;
    m_cur = 0; shown_cur = 0; cur_at = -1; cur_next = 0; idle_at = 0;
    wr_sel_at.delete(); wr_seg_at.delete(); clr_at.delete(); push_at.delete();
    fifo_q.delete();
    awaiting = 1'b0; load_exp = 1'b0; load_data = 0;
  endfunction

  function automatic void sched_wr(input int at, input int sel, input int seg);
    wr_sel_at[at] = sel;
    wr_seg_at[at] = seg;
  endfunction

  // Byte accepted in cycle c: effects appear from cycle c+2 on.
  function automatic void model_accept(input int c, input int b);
    int s;
    int base = c + 2;
    idle_at = c + 2;
    if (b == 'h0D) begin
      m_cur = 0;
    end else if (b == 'h0C) begin
      for (int i = 0; i < DIGIT_CT; i++) m_fb[i] = 0;
      m_cur = 0;
      clr_at[base] = 1'b1;
      idle_at = c + 3;
    end else if (b == 'h08) begin
      if (m_cur > 0) begin
        m_cur--;
        m_fb[m_cur] = 0;
        sched_wr(base, m_cur, 0);
        push_at[base] = 0;
        idle_at = c + 3;
      end
    end else if (b >= 'h20 && b <= 'h7E) begin
      if (b == 'h2E && m_cur > 0) begin
        m_fb[m_cur-1] = m_fb[m_cur-1] | 'h80;
        sched_wr(base, m_cur - 1, m_fb[m_cur-1]);
        push_at[base] = m_fb[m_cur-1];
        idle_at = c + 3;
      end else begin
        s = seg_model(b);
        if (m_cur < DIGIT_CT) begin
          m_fb[m_cur] = s;
          sched_wr(base, m_cur, s);
          push_at[base] = s;
          m_cur++;
          idle_at = c + 3;
        end else begin
          for (int i = 0; i < DIGIT_CT - 1; i++) m_fb[i] = m_fb[i+1];
          m_fb[DIGIT_CT-1] = s;
          for (int i = 0; i < DIGIT_CT; i++) sched_wr(base + i, i, m_fb[i]);
          push_at[base] = s;
          idle_at = base + DIGIT_CT;
        end
      end
    end
    cur_next = m_cur;
    cur_at   = c + 2;
  endfunction

  initial begin : compare
    bit exp_wr, busy, pop, push, ovf;
    cyc = 0;
    model_reset();
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        model_reset();
      end else begin
        if (bus.wr_en) begin
          wlog.push_back((int'(bus.wr_sel) << 8) | int'(bus.wr_seg));
          wcyc.push_back(cyc);
        end
        if (bus.clr_pulse) clr_count++;
        if (bus.echo_ovf)  ovf_count++;
        if (bus.rx_drop)   drop_count++;
        if (bus.tx_load)   llog.push_back(int'(bus.tx_data));

        exp_wr = wr_sel_at.exists(cyc);
        check("wr_en", int'(bus.wr_en), int'(exp_wr));
        if (exp_wr) begin
          check("wr_sel", int'(bus.wr_sel), wr_sel_at[cyc]);
          check("wr_seg", int'(bus.wr_seg), wr_seg_at[cyc]);
        end
        check("clr_pulse", int'(bus.clr_pulse), int'(clr_at.exists(cyc)));
        if (cyc == cur_at) shown_cur = cur_next;
        check("cursor", int'(bus.cursor), shown_cur);
        busy = (cyc < idle_at);
        check("rx_drop", int'(bus.rx_drop), int'(bus.rx_valid && busy));
        check("tx_load", int'(bus.tx_load), int'(load_exp));
        if (load_exp) check("tx_data", int'(bus.tx_data), load_data);

        pop  = (fifo_q.size() > 0) && bus.tx_load_ok && !awaiting;
        push = push_at.exists(cyc);
        ovf  = push && (fifo_q.size() == ECHO_DEPTH) && !pop;
        check("echo_ovf", int'(bus.echo_ovf), int'(ovf));
        load_exp = pop;
        if (pop) begin
          load_data = fifo_q.pop_front();
          awaiting  = 1'b1;
        end else if (!bus.tx_load_ok) begin
          awaiting = 1'b0;
        end
        if (push && !ovf) fifo_q.push_back(push_at[cyc]);
        if (bus.rx_valid && !busy) model_accept(cyc, int'(bus.rx_data));
      end
      cyc++;
    end
  end

  // Behavioural UART transmitter: busy for a few cycles after each load.
  initial begin : uart_tx
    bus.tx_load_ok = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      if (ok_hold) bus.tx_load_ok = 1'b0;
      else if (ok_busy > 0) begin
        ok_busy--;
        if (ok_busy == 0) bus.tx_load_ok = 1'b1;
      end else if (bus.tx_load) begin
        bus.tx_load_ok = 1'b0;
        ok_busy = $urandom_range(1, 5);
      end else bus.tx_load_ok = 1'b1;
    end
  end

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc < idle_at && n < 100) begin step(); n++; end
    if (n >= 100) begin errors++; $display("FAIL wait_idle timeout at cycle %0d", cyc); end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((fifo_q.size() != 0 || load_exp || cyc < idle_at) && n < 400) begin step(); n++; end
    if (n >= 400) begin errors++; $display("FAIL wait_drain timeout at cycle %0d", cyc); end
  endtask

  task automatic send_idle(input logic [7:0] b);
    send(b);
    wait_idle();
  endtask

  initial begin : stim
    int t0, n0, d0, c0, o0;
    int exp2 [8] = '{'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F};
    int exp5 [4] = '{'h77, 'h7C, 'h39, 'h5E};
    int r;
    logic [7:0] b;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;
    check("reset_wr_en", int'(bus.wr_en), 0);
    check("reset_cursor", int'(bus.cursor), 0);
    check("reset_tx_load", int'(bus.tx_load), 0);
    check("reset_clr", int'(bus.clr_pulse), 0);

    wlog.delete(); wcyc.delete(); llog.delete();
    t0 = cyc;
    send_idle(8'h31);
    send_idle(8'h32);
    check("t1_latency", get(wcyc, 0) - t0, 2);
    check("t1_w0", get(wlog, 0), 'h006);
    check("t1_w1", get(wlog, 1), 'h15B);
    check("t1_cursor", int'(bus.cursor), 2);
    wait_drain();
    check("t1_echo0", get(llog, 0), 'h06);
    check("t1_echo1", get(llog, 1), 'h5B);

    send_idle(8'h0C);
    for (int d = 0; d < 8; d++) send_idle(8'(8'h30 + d));
    wlog.delete(); wcyc.delete();
    send(8'h38);
    step(); step();
    d0 = drop_count;
    send(8'h5A);
    wait_idle();
    check("t6_drop", drop_count - d0, 1);
    check("t2_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8; i++) check("t2_scroll", get(wlog, i), (i << 8) | exp2[i]);
    check("t2_span", get(wcyc, 7) - get(wcyc, 0), 7);
    check("t2_cursor", int'(bus.cursor), 8);

    send(8'h39);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_wr_en", int'(bus.wr_en), 0);
    check("t6_rst_cursor", int'(bus.cursor), 0);

    wlog.delete();
    send_idle(8'h34);
    send_idle(8'h2E);
    check("t3_w1", get(wlog, 1), 'h0E6);
    check("t3_cursor", int'(bus.cursor), 1);
    wlog.delete();
    send_idle(8'h08);
    check("t3_bs", get(wlog, 0), 'h000);
    check("t3_bs_cursor", int'(bus.cursor), 0);
    n0 = wlog.size();
    send_idle(8'h08);
    check("t3_bs_noop", wlog.size(), n0);

    send_idle(8'h31);
    send_idle(8'h32);
    wait_drain();
    llog.delete();
    c0 = clr_count;
    send_idle(8'h0C);
    check("t4_clr", clr_count - c0, 1);
    check("t4_cursor", int'(bus.cursor), 0);
    wait_drain();
    check("t4_no_echo", llog.size(), 0);
    wlog.delete();
    send_idle(8'h41);
    check("t4_A", get(wlog, 0), 'h077);

    wait_drain();
    ok_hold = 1'b1;
    step(); step();
    send_idle(8'h0C);
    o0 = ovf_count;
    foreach (exp5[i]) send_idle(8'(8'h41 + i));
    send_idle(8'h45);
    send_idle(8'h46);
    check("t5_ovf", ovf_count - o0, 2);
    llog.delete();
    ok_hold = 1'b0;
    wait_drain();
    check("t5_nload", llog.size(), 4);
    for (int i = 0; i < 4; i++) check("t5_echo", get(llog, i), exp5[i]);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      b = 8'($urandom_range('h20, 'h7E));
      else if (r < 55) b = 8'($urandom_range('h30, 'h39));
      else if (r < 65) b = 8'h2E;
      else if (r < 75) b = 8'h08;
      else if (r < 80) b = 8'h0D;
      else if (r < 84) b = 8'h0C;
      else if (r < 92) b = 8'($urandom_range(0, 'h1F));
      else             b = 8'($urandom_range('h7F, 'hFF));
      send(b);
      if ($urandom_range(0, 3) != 0) wait_idle();
      repeat ($urandom_range(0, 3)) step();
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
